// File: rtl/p4_fsm_controller_pkg.sv
// Shared definitions for the Simple RISC Machine sequencer: state codes,
// instruction field encodings, register-select and writeback encodings.
package p4_ctrl_pkg;

    localparam int P4_STATE_W = 4;

    localparam logic [P4_STATE_W-1:0] ST_WAIT     = 4'd0;
    localparam logic [P4_STATE_W-1:0] ST_DECODE   = 4'd1;
    localparam logic [P4_STATE_W-1:0] ST_WR_IMM   = 4'd2;
    localparam logic [P4_STATE_W-1:0] ST_GET_A    = 4'd3;
    localparam logic [P4_STATE_W-1:0] ST_GET_B    = 4'd4;
    localparam logic [P4_STATE_W-1:0] ST_EXEC     = 4'd5;
    localparam logic [P4_STATE_W-1:0] ST_WRITE_RD = 4'd6;
    localparam logic [P4_STATE_W-1:0] ST_ERR      = 4'd7;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_MDATA = 2'b10;
    localparam logic [1:0] VSEL_PC    = 2'b11;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic       write;
        logic       err;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{w: 1'b1, nsel: NSEL_NONE, loada: 1'b0,
                                   loadb: 1'b0, loadc: 1'b0, loads: 1'b0,
                                   asel: 1'b0, bsel: 1'b0, vsel: VSEL_C,
                                   write: 1'b0, err: 1'b0};

endpackage

// File: rtl/p4_fsm_controller_if.sv
// Decoder/datapath-facing bundle of the sequencer: instruction fields in,
// datapath control strobes out.
interface p4_ctrl_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       err;

    modport master (
        input  s, opcode, op,
        output w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
    );

    modport slave (
        output s, opcode, op,
        input  w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, err
    );
endinterface

// File: rtl/p4_fsm_controller_outdec.sv
// State -> datapath control vector decoder. Illegal-trap flag only exists
// when P4_ILLEGAL_TRAP_EN is defined.
module p4_ctrl_outdec
    import p4_ctrl_pkg::*;
(
    input  logic [P4_STATE_W-1:0] state,
    input  logic [2:0]            opcode,
    input  logic [1:0]            op,
    output ctrl_t                 ctrl
);

    // Per-state control decode; opcode/op are the latched instruction, not live inputs
    always_comb begin
        ctrl = '0;
        case (state)
            ST_WAIT: begin
                ctrl = CTRL_IDLE;
            end
            ST_DECODE: begin
                ctrl = '0;
            end
            ST_WR_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM8;
                ctrl.write = 1'b1;
            end
            ST_GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            ST_GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            ST_EXEC: begin
                // CMP only updates flags so C keeps its previous result
                if ({opcode, op} == {OPC_ALU, OP_CMP}) begin
                    ctrl.loads = 1'b1;
                end else begin
                    ctrl.loadc = 1'b1;
                end
                if ((opcode == OPC_MOV) || (op == OP_MVN)) begin
                    ctrl.asel = 1'b1;
                end else begin
                    ctrl.asel = 1'b0;
                end
            end
            ST_WRITE_RD: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
            ST_ERR: begin
`ifdef P4_ILLEGAL_TRAP_EN
                ctrl.err = 1'b1;
`else
                ctrl = '0;
`endif
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/p4_fsm_controller.sv
// Moore sequencer for the Simple RISC Machine datapath. Define
// P4_ILLEGAL_TRAP_EN to trap undecoded instructions in a sticky ERR state.
module p4_fsm_controller
    import p4_ctrl_pkg::*;
#(
    parameter int STATE_W = P4_STATE_W
) (
    input  logic          clk,
    input  logic          reset,
    p4_ctrl_if.master     bus
);

`ifdef P4_ILLEGAL_TRAP_EN
    localparam logic [P4_STATE_W-1:0] ST_UNDEC = ST_ERR;
`else
    localparam logic [P4_STATE_W-1:0] ST_UNDEC = ST_WAIT;
`endif

    logic [STATE_W-1:0] state_r;
    logic [STATE_W-1:0] state_nxt_s;
    logic [4:0]         instr_r;
    logic [4:0]         instr_nxt_s;
    ctrl_t              ctrl_r;
    ctrl_t              ctrl_nxt_s;

    // Capture {opcode, op} on the start edge so later states never look at live inputs
    always_comb begin
        instr_nxt_s = instr_r;
        if ((state_r == ST_WAIT) && bus.s) begin
            instr_nxt_s = {bus.opcode, bus.op};
        end else begin
            instr_nxt_s = instr_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (bus.s) begin
                    state_nxt_s = ST_DECODE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                if (instr_r == {OPC_MOV, OP_MOV_IMM}) begin
                    state_nxt_s = ST_WR_IMM;
                end else if ((instr_r == {OPC_MOV, OP_MOV_REG}) ||
                             (instr_r == {OPC_ALU, OP_MVN})) begin
                    state_nxt_s = ST_GET_B;
                end else if (instr_r[4:2] == OPC_ALU) begin
                    state_nxt_s = ST_GET_A;
                end else begin
                    state_nxt_s = ST_UNDEC;
                end
            end
            ST_WR_IMM:   state_nxt_s = ST_WAIT;
            ST_GET_A:    state_nxt_s = ST_GET_B;
            ST_GET_B:    state_nxt_s = ST_EXEC;
            ST_EXEC: begin
                if (instr_r == {OPC_ALU, OP_CMP}) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_WRITE_RD;
                end
            end
            ST_WRITE_RD: state_nxt_s = ST_WAIT;
            ST_ERR:      state_nxt_s = ST_UNDEC;
            default:     state_nxt_s = ST_WAIT;
        endcase
    end

    // Decode the upcoming state so the control outputs leave a flop in step with it
    p4_ctrl_outdec u_outdec (
        .state  (state_nxt_s),
        .opcode (instr_nxt_s[4:2]),
        .op     (instr_nxt_s[1:0]),
        .ctrl   (ctrl_nxt_s)
    );

    // State, latched instruction and registered control vector
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_WAIT;
            instr_r <= 5'b00000;
            ctrl_r  <= CTRL_IDLE;
        end else begin
            state_r <= state_nxt_s;
            instr_r <= instr_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
        end
    end

    assign bus.w     = ctrl_r.w;
    assign bus.nsel  = ctrl_r.nsel;
    assign bus.loada = ctrl_r.loada;
    assign bus.loadb = ctrl_r.loadb;
    assign bus.loadc = ctrl_r.loadc;
    assign bus.loads = ctrl_r.loads;
    assign bus.asel  = ctrl_r.asel;
    assign bus.bsel  = ctrl_r.bsel;
    assign bus.vsel  = ctrl_r.vsel;
    assign bus.write = ctrl_r.write;
    assign bus.err   = ctrl_r.err;

endmodule

// File: tb/tb_p4_fsm_controller.sv
// Directed bench for p4_fsm_controller; expected control vectors are hand-built
// as {w, nsel[2:0], loada, loadb, loadc, loads, asel, bsel, vsel[1:0], write, err}.
module tb_p4_fsm_controller;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    p4_ctrl_if bus ();

    p4_fsm_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [13:0] E_WAIT   = 14'b1_000_0_0_0_0_0_0_00_0_0;
    localparam logic [13:0] E_DEC    = 14'b0_000_0_0_0_0_0_0_00_0_0;
    localparam logic [13:0] E_WRIMM  = 14'b0_001_0_0_0_0_0_0_01_1_0;
    localparam logic [13:0] E_GETA   = 14'b0_001_1_0_0_0_0_0_00_0_0;
    localparam logic [13:0] E_GETB   = 14'b0_100_0_1_0_0_0_0_00_0_0;
    localparam logic [13:0] E_EXADD  = 14'b0_000_0_0_1_0_0_0_00_0_0;
    localparam logic [13:0] E_EXCMP  = 14'b0_000_0_0_0_1_0_0_00_0_0;
    localparam logic [13:0] E_EXZA   = 14'b0_000_0_0_1_0_1_0_00_0_0;
    localparam logic [13:0] E_WRD    = 14'b0_010_0_0_0_0_0_0_00_1_0;
    localparam logic [13:0] E_ERR    = 14'b0_000_0_0_0_0_0_0_00_0_1;

    function automatic logic [13:0] obs();
        return {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                bus.asel, bus.bsel, bus.vsel, bus.write, bus.err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.s = 1'b1; bus.opcode = 3'b110; bus.op = 2'b10;
        tick(); tick();
        total++;
        if (obs() !== E_WAIT) begin
            $display("FAIL reset_init got=%b exp=%b", obs(), E_WAIT); bad++;
        end
        reset = 1'b0; bus.s = 1'b0;
        tick();
        // abort an ADD while in GET_B
        bus.opcode = 3'b101; bus.op = 2'b00; bus.s = 1'b1;
        tick(); bus.s = 1'b0;
        tick(); tick();
        total++;
        if (obs() !== E_GETB) begin
            $display("FAIL reset_pre_getb got=%b exp=%b", obs(), E_GETB); bad++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (obs() !== E_WAIT) begin
            $display("FAIL reset_abort got=%b exp=%b", obs(), E_WAIT); bad++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs() !== E_WAIT) begin
                $display("FAIL reset_after%0d got=%b exp=%b", i, obs(), E_WAIT); bad++;
            end
        end
    endtask

    task automatic test_mov_imm();
        logic [13:0] exp [3] = '{E_DEC, E_WRIMM, E_WAIT};
        bus.opcode = 3'b110; bus.op = 2'b10; bus.s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.s = 1'b0;
            total++;
            if (obs() !== exp[i]) begin
                $display("FAIL mov_imm edge%0d got=%b exp=%b", i + 1, obs(), exp[i]); bad++;
            end
        end
    endtask

    task automatic test_alu3(input logic [1:0] op_v);
        logic [13:0] exp [6] = '{E_DEC, E_GETA, E_GETB, E_EXADD, E_WRD, E_WAIT};
        bus.opcode = 3'b101; bus.op = op_v; bus.s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.s = 1'b0;
            total++;
            if (obs() !== exp[i]) begin
                $display("FAIL alu_op%b edge%0d got=%b exp=%b", op_v, i + 1, obs(), exp[i]); bad++;
            end
        end
    endtask

    task automatic test_cmp();
        logic [13:0] exp [5] = '{E_DEC, E_GETA, E_GETB, E_EXCMP, E_WAIT};
        bus.opcode = 3'b101; bus.op = 2'b01; bus.s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.s = 1'b0;
            total++;
            if (obs() !== exp[i]) begin
                $display("FAIL cmp edge%0d got=%b exp=%b", i + 1, obs(), exp[i]); bad++;
            end
        end
    endtask

    task automatic test_zero_a(input logic [2:0] opc_v, input logic [1:0] op_v);
        logic [13:0] exp [5] = '{E_DEC, E_GETB, E_EXZA, E_WRD, E_WAIT};
        bus.opcode = opc_v; bus.op = op_v; bus.s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.s = 1'b0;
            total++;
            if (obs() !== exp[i]) begin
                $display("FAIL zero_a_%b_%b edge%0d got=%b exp=%b", opc_v, op_v, i + 1, obs(), exp[i]); bad++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp [11] = '{E_DEC, E_GETB, E_EXZA, E_WRD, E_WAIT,
                                  E_DEC, E_GETB, E_EXZA, E_WRD, E_WAIT, E_WAIT};
        bus.opcode = 3'b101; bus.op = 2'b11; bus.s = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (i == 5) bus.s = 1'b0;
            total++;
            if (obs() !== exp[i]) begin
                $display("FAIL b2b edge%0d got=%b exp=%b", i + 1, obs(), exp[i]); bad++;
            end
        end
    endtask

    task automatic test_illegal();
        bus.opcode = 3'b111; bus.op = 2'b00; bus.s = 1'b1;
        tick();
        total++;
        if (obs() !== E_DEC) begin
            $display("FAIL illegal_decode got=%b exp=%b", obs(), E_DEC); bad++;
        end
`ifdef P4_ILLEGAL_TRAP_EN
        for (int i = 0; i < 11; i++) begin
            tick();
            total++;
            if (obs() !== E_ERR) begin
                $display("FAIL illegal_err%0d got=%b exp=%b", i, obs(), E_ERR); bad++;
            end
        end
        reset = 1'b1; bus.s = 1'b0;
        tick();
        reset = 1'b0;
        total++;
        if (obs() !== E_WAIT) begin
            $display("FAIL illegal_clear got=%b exp=%b", obs(), E_WAIT); bad++;
        end
`else
        bus.s = 1'b0;
        tick();
        total++;
        if (obs() !== E_WAIT) begin
            $display("FAIL illegal_nop got=%b exp=%b", obs(), E_WAIT); bad++;
        end
        tick();
        total++;
        if (bus.err !== 1'b0) begin
            $display("FAIL illegal_err_tied got=%b exp=0", bus.err); bad++;
        end
`endif
    endtask

    initial begin
        reset = 1'b1; bus.s = 1'b0; bus.opcode = 3'b000; bus.op = 2'b00;
        test_reset();
        test_mov_imm();
        test_alu3(2'b00);
        test_alu3(2'b10);
        test_cmp();
        test_zero_a(3'b101, 2'b11);
        test_zero_a(3'b110, 2'b00);
        test_back_to_back();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
